alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits.
REQ-002 Port: clk  input  1  single clock, all state on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: req0_valid / req1_valid  input  1  requester n presents an operation.
REQ-005 Port: req0_ready / req1_ready  output  1  operation from requester n accepted this cycle.
REQ-006 Port: req0_op / req1_op  input  4  ALU control code.
REQ-007 Port: req0_a, req0_b / req1_a, req1_b  input  WIDTH  operands.
REQ-008 Port: rsp0_valid / rsp1_valid  output  1  response available for requester n.
REQ-009 Port: rsp0_ready / rsp1_ready  input  1  requester n consumes response.
REQ-010 Port: rsp_result  output  WIDTH  result shared by both response channels.
REQ-011 Port: rsp_err  output  1  illegal op code in the responded operation.
REQ-012 Port: alu_ctrl  output  4, alu_a / alu_b  output  WIDTH  drive the shared combinational ALU.
REQ-013 Port: alu_result  input  WIDTH  ALU output.
REQ-014 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-015 FSM states: IDLE, EXEC, RESP; exactly one active.
REQ-016 Legal op codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR; all others illegal.
REQ-017 IDLE, at least one reqN_valid: grant one requester, reqN_ready=1 for winner only, combinationally, same cycle.
REQ-018 Arbitration round-robin: on both valid, grant the requester not granted last; single valid is granted regardless of pointer.
REQ-019 Priority pointer updates only on an accepted request; after reset, requester 0 wins a tie.
REQ-020 On accept: capture op, a, b, owner id into registers; legal op -> EXEC, illegal op -> RESP with err=1, result=0.
REQ-021 reqN_ready SHALL be 0 in EXEC and RESP; requests held valid there are not lost and compete on return to IDLE.
REQ-022 alu_ctrl, alu_a, alu_b SHALL always drive the captured registers (stable for whole EXEC cycle).
REQ-023 EXEC lasts exactly one cycle; alu_result registered into result register at its end; next state RESP, err=0.
REQ-024 RESP: rspN_valid=1 for owner only; rsp_result/rsp_err held stable until consumed.
REQ-025 RESP with owner's rspN_ready=1: response consumed that edge, next state IDLE; non-owner rsp_ready ignored.
REQ-026 Latency: accept at edge N -> rsp_valid high from cycle N+2 (legal) or N+1 (illegal); throughput at best one op per 3 cycles.
REQ-027 No new accept in the consume cycle; IDLE always takes at least one cycle.
REQ-028 Result width WIDTH; block performs no arithmetic itself, passes alu_result unchanged.

Reset
REQ-029 rst_n low asynchronously forces: state IDLE, pointer to favor requester 0, captured op/a/b/result 0, err 0, owner 0.
REQ-030 Resulting outputs during reset: req*_ready 0, rsp*_valid 0, rsp_result 0, rsp_err 0, alu_ctrl 0000, alu_a/alu_b 0, busy 0.
REQ-031 Reset during EXEC or RESP discards in-flight operation; no response is ever issued for it.
REQ-032 First accept allowed on the first rising edge after rst_n deasserts with a valid request.

Verification
REQ-033 req0 op=0010 a=5 b=7, rsp0_ready=1 -> req0_ready at accept, rsp0_valid two cycles later, rsp_result=12, rsp_err=0.
REQ-034 Both valid continuously after reset, op=0110 a=3 b=5 -> grants alternate 0,1,0,1; each rsp_result=0xFFFFFFFE.
REQ-035 req1 op=0011 -> rsp1_valid one cycle after accept, rsp_err=1, rsp_result=0, alu never sees EXEC.
REQ-036 req0 op=0111 a=2 b=9, rsp0_ready held 0 for 4 cycles -> rsp0_valid and rsp_result=1 stable, req1_ready stays 0, busy 1.
REQ-037 rst_n pulsed low during EXEC -> all outputs at reset values immediately, no rsp*_valid afterwards for that op.
REQ-038 Responding to wrong requester: rsp1_ready=1 while owner is 0 -> no state change, rsp0_valid remains 1.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one external combinational ALU through round-robin arbitration.
// Latency: accept -> response after 2 cycles for a legal op, 1 cycle for an illegal op. At best one op per 3 cycles.
// Backpressure: req*_ready stays low while an op is in flight. The response is held until the owner asserts rsp_ready.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_err,
    output logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             prio_q;     // requester that wins when both are valid
    logic             owner_q;    // requester the in-flight op belongs to
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q, result_q;
    logic             err_q;

    logic             winner;
    logic             accept;
    logic             sel_legal;
    logic [3:0]       sel_op;
    logic [WIDTH-1:0] sel_a, sel_b;

    // Pick the winner: a lone requester always wins, and a tie goes to the pointer.
    always_comb begin
        winner = 1'b0;
        if (req0_valid && req1_valid) begin
            winner = prio_q;
        end else if (req1_valid) begin
            winner = 1'b1;
        end
    end

    assign sel_op = winner ? req1_op : req0_op;
    assign sel_a  = winner ? req1_a  : req0_a;
    assign sel_b  = winner ? req1_b  : req0_b;

    // Decode the winner's op code against the set of ops the ALU supports.
    always_comb begin
        case (sel_op)
            4'b0000, 4'b0001, 4'b0010,
            4'b0110, 4'b0111, 4'b1100: sel_legal = 1'b1;
            default:                   sel_legal = 1'b0;
        endcase
    end

    // Hold the state register; reset drops any in-flight op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Compute the next state and the handshake outputs. Accept is masked while reset is held.
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        case (state_q)
            IDLE: begin
                accept = rst_n && (req0_valid || req1_valid);
                if (accept) begin
                    state_d = sel_legal ? EXEC : RESP;
                end
            end
            EXEC: begin
                state_d = RESP;
            end
            RESP: begin
                rsp0_valid = !owner_q;
                rsp1_valid = owner_q;
                if (owner_q ? rsp1_ready : rsp0_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Capture the accepted op and advance the pointer. Latch the ALU output at the end of EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q   <= 1'b0;
            owner_q  <= 1'b0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else if (accept) begin
            prio_q   <= ~winner;
            owner_q  <= winner;
            op_q     <= sel_op;
            a_q      <= sel_a;
            b_q      <= sel_b;
            result_q <= '0;
            err_q    <= ~sel_legal;
        end else if (state_q == EXEC) begin
            result_q <= alu_result;
            err_q    <= 1'b0;
        end
    end

    assign req0_ready = accept && !winner;
    assign req1_ready = accept && winner;
    assign rsp_result = result_q;
    assign rsp_err    = err_q;
    assign alu_ctrl   = op_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scenarios plus a randomized transaction-level scoreboard for alu_arbiter.
// Latency: checks the exact accept-to-response cycle counts and the round-robin grant order.
// Backpressure: randomly stalls response consumption, and keeps unserved requests valid until they are granted.
module tb_alu_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req1_valid, req0_ready, req1_ready;
    logic [3:0]   req0_op, req1_op;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [W-1:0] rsp_result, alu_a, alu_b, alu_result;
    logic         rsp_err, busy;
    logic [3:0]   alu_ctrl;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_err(rsp_err),
        .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .busy(busy)
    );

    // External ALU. An unknown code returns a marker value, so a leak of it into a response is visible.
    function automatic logic [W-1:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1100: return ~(a | b);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic bit is_legal(input logic [3:0] op);
        return (op == 4'b0000) || (op == 4'b0001) || (op == 4'b0010) ||
               (op == 4'b0110) || (op == 4'b0111) || (op == 4'b1100);
    endfunction

    assign alu_result = alu_fn(alu_ctrl, alu_a, alu_b);

    task automatic clear_inputs();
        req0_valid = 1'b0; req0_op = 4'h0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = 4'h0; req1_a = '0; req1_b = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        req0_valid = 1'b1; req1_valid = 1'b1; req0_op = 4'h2; req0_a = 32'h55; req1_a = 32'h66;
        rst_n = 1'b0;
        #3;
        n_cmp++; if ({req1_ready, req0_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=00", {req1_ready, req0_ready}); end
        n_cmp++; if ({rsp1_valid, rsp0_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=00", {rsp1_valid, rsp0_valid}); end
        n_cmp++; if (rsp_result !== 32'h0 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp got=%h/%b exp=0/0", rsp_result, rsp_err); end
        n_cmp++; if (alu_ctrl !== 4'h0 || alu_a !== 32'h0 || alu_b !== 32'h0) begin n_fail++; $display("FAIL reset_alu got=%h %h %h exp=0 0 0", alu_ctrl, alu_a, alu_b); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_add();
        do_reset();
        req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 32'd5; req0_b = 32'd7; rsp0_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if ({req1_ready, req0_ready} !== 2'b01) begin n_fail++; $display("FAIL add_grant got=%b exp=01", {req1_ready, req0_ready}); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL add_idle_busy got=%b exp=0", busy); end
        cyc(); req0_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1 || rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL add_exec got busy=%b rsp0=%b exp 1/0", busy, rsp0_valid); end
        n_cmp++; if (alu_ctrl !== 4'b0010 || alu_a !== 32'd5 || alu_b !== 32'd7) begin n_fail++; $display("FAIL add_alu_drive got=%h %h %h exp=2 5 7", alu_ctrl, alu_a, alu_b); end
        cyc();
        @(negedge clk);
        n_cmp++; if ({rsp1_valid, rsp0_valid} !== 2'b01) begin n_fail++; $display("FAIL add_rsp_valid got=%b exp=01", {rsp1_valid, rsp0_valid}); end
        n_cmp++; if (rsp_result !== 32'd12 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL add_result got=%h/%b exp=c/0", rsp_result, rsp_err); end
        cyc();
        @(negedge clk);
        n_cmp++; if (rsp0_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL add_consumed got rsp0=%b busy=%b exp 0/0", rsp0_valid, busy); end
    endtask

    task automatic test_round_robin();
        int grants[$];
        do_reset();
        req0_valid = 1'b1; req0_op = 4'b0110; req0_a = 32'd3; req0_b = 32'd5;
        req1_valid = 1'b1; req1_op = 4'b0110; req1_a = 32'd3; req1_b = 32'd5;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (req0_ready) grants.push_back(0);
            if (req1_ready) grants.push_back(1);
            if (rsp0_valid || rsp1_valid) begin
                n_cmp++; if (rsp_result !== 32'hFFFF_FFFE || rsp_err !== 1'b0) begin n_fail++; $display("FAIL rr_result got=%h/%b exp=fffffffe/0", rsp_result, rsp_err); end
            end
            cyc();
        end
        n_cmp++; if (grants.size() != 4) begin n_fail++; $display("FAIL rr_count got=%0d exp=4", grants.size()); end
        for (int i = 0; i < grants.size(); i++) begin
            n_cmp++; if (grants[i] != (i % 2)) begin n_fail++; $display("FAIL rr_order idx=%0d got=%0d exp=%0d", i, grants[i], i % 2); end
        end
    endtask

    task automatic test_illegal();
        do_reset();
        req1_valid = 1'b1; req1_op = 4'b0011; req1_a = 32'd4; req1_b = 32'd4; rsp1_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if ({req1_ready, req0_ready} !== 2'b10) begin n_fail++; $display("FAIL ill_grant got=%b exp=10", {req1_ready, req0_ready}); end
        cyc(); req1_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if ({rsp1_valid, rsp0_valid} !== 2'b10) begin n_fail++; $display("FAIL ill_rsp_valid got=%b exp=10", {rsp1_valid, rsp0_valid}); end
        n_cmp++; if (rsp_result !== 32'h0 || rsp_err !== 1'b1) begin n_fail++; $display("FAIL ill_result got=%h/%b exp=0/1", rsp_result, rsp_err); end
        cyc();
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || rsp1_valid !== 1'b0) begin n_fail++; $display("FAIL ill_done got busy=%b rsp1=%b exp 0/0", busy, rsp1_valid); end
    endtask

    task automatic test_stall();
        do_reset();
        req0_valid = 1'b1; req0_op = 4'b0111; req0_a = 32'd2; req0_b = 32'd9;
        @(negedge clk);
        cyc(); req0_valid = 1'b0;
        req1_valid = 1'b1; req1_op = 4'b0001; req1_a = 32'h10; req1_b = 32'h01;
        cyc();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++; if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0) begin n_fail++; $display("FAIL stall_valid cyc=%0d got=%b%b exp=01", c, rsp1_valid, rsp0_valid); end
            n_cmp++; if (rsp_result !== 32'd1 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL stall_result cyc=%0d got=%h/%b exp=1/0", c, rsp_result, rsp_err); end
            n_cmp++; if (req1_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL stall_hold cyc=%0d got rdy1=%b busy=%b exp 0/1", c, req1_ready, busy); end
            cyc();
        end
        rsp0_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL stall_consume_cycle got rdy1=%b exp=0", req1_ready); end
        cyc(); rsp0_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL stall_held_req got rdy1=%b exp=1", req1_ready); end
        cyc(); req1_valid = 1'b0;
    endtask

    task automatic test_reset_exec();
        do_reset();
        req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 32'd9; req0_b = 32'd1;
        req1_valid = 1'b1; req1_op = 4'b0000;
        @(negedge clk);
        cyc(); req0_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || {req1_ready, req0_ready} !== 2'b00) begin n_fail++; $display("FAIL rexec_ctrl got busy=%b rdy=%b%b exp 0/00", busy, req1_ready, req0_ready); end
        n_cmp++; if (alu_ctrl !== 4'h0 || alu_a !== 32'h0 || alu_b !== 32'h0) begin n_fail++; $display("FAIL rexec_alu got=%h %h %h exp=0 0 0", alu_ctrl, alu_a, alu_b); end
        n_cmp++; if ({rsp1_valid, rsp0_valid} !== 2'b00 || rsp_result !== 32'h0 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL rexec_rsp got v=%b%b r=%h e=%b exp 00/0/0", rsp1_valid, rsp0_valid, rsp_result, rsp_err); end
        req1_valid = 1'b0; rsp0_ready = 1'b1;
        cyc(); rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++; if ({rsp1_valid, rsp0_valid} !== 2'b00) begin n_fail++; $display("FAIL rexec_no_rsp cyc=%0d got=%b%b exp=00", c, rsp1_valid, rsp0_valid); end
            cyc();
        end
    endtask

    task automatic test_wrong_owner();
        do_reset();
        req0_valid = 1'b1; req0_op = 4'b0000; req0_a = 32'hF0F0; req0_b = 32'h0FF0;
        rsp1_ready = 1'b1;
        @(negedge clk);
        cyc(); req0_valid = 1'b0;
        cyc();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++; if ({rsp1_valid, rsp0_valid} !== 2'b01 || busy !== 1'b1) begin n_fail++; $display("FAIL wrong_owner cyc=%0d got v=%b%b busy=%b exp 01/1", c, rsp1_valid, rsp0_valid, busy); end
            n_cmp++; if (rsp_result !== 32'h00F0) begin n_fail++; $display("FAIL wrong_owner_result got=%h exp=f0", rsp_result); end
            cyc();
        end
        rsp0_ready = 1'b1;
        cyc();
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wrong_owner_release got busy=%b exp=0", busy); end
    endtask

    // Transaction-level scoreboard: each requester holds its op until granted, and
    // every grant and response is checked against the arbitration and latency rules.
    task automatic test_random(input int ncyc);
        logic [3:0]   ops [8];
        bit           pend [2];
        logic [3:0]   op [2];
        logic [W-1:0] a [2], b [2];
        bit           outst;
        int           own, age, need, last, win;
        logic [W-1:0] er;
        bit           ee;
        logic [1:0]   exp_r, exp_v;
        ops = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC, 4'h3, 4'hF};
        pend[0] = 0; pend[1] = 0; outst = 0; own = 0; age = 0; need = 0; last = 1; er = '0; ee = 0;
        do_reset();
        for (int c = 0; c < ncyc; c++) begin
            cyc();
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i] = 1;
                    op[i] = ops[$urandom_range(0, 7)];
                    a[i] = $urandom;
                    b[i] = ($urandom_range(0, 3) == 0) ? a[i] : $urandom;
                end
            end
            req0_valid = pend[0]; req0_op = op[0]; req0_a = a[0]; req0_b = b[0];
            req1_valid = pend[1]; req1_op = op[1]; req1_a = a[1]; req1_b = b[1];
            rsp0_ready = $urandom_range(0, 1); rsp1_ready = $urandom_range(0, 1);
            @(negedge clk);
            win = -1;
            exp_r = 2'b00;
            if (!outst) begin
                if (pend[0] && pend[1]) win = 1 - last;
                else if (pend[0]) win = 0;
                else if (pend[1]) win = 1;
                if (win >= 0) exp_r[win] = 1'b1;
            end
            n_cmp++; if ({req1_ready, req0_ready} !== exp_r) begin n_fail++; $display("FAIL rnd_grant cyc=%0d got=%b%b exp=%b", c, req1_ready, req0_ready, exp_r); end
            n_cmp++; if (busy !== outst) begin n_fail++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", c, busy, outst); end
            exp_v = 2'b00;
            if (outst && age >= need) exp_v[own] = 1'b1;
            n_cmp++; if ({rsp1_valid, rsp0_valid} !== exp_v) begin n_fail++; $display("FAIL rnd_rsp_valid cyc=%0d got=%b%b exp=%b", c, rsp1_valid, rsp0_valid, exp_v); end
            if (exp_v != 2'b00) begin
                n_cmp++; if (rsp_result !== er || rsp_err !== ee) begin n_fail++; $display("FAIL rnd_result cyc=%0d got=%h/%b exp=%h/%b", c, rsp_result, rsp_err, er, ee); end
            end
            if (outst) begin
                if (age >= need && ((own == 0) ? rsp0_ready : rsp1_ready)) outst = 0;
                else age++;
            end else if (win >= 0) begin
                outst = 1; own = win; last = win; pend[win] = 0; age = 1;
                need = is_legal(op[win]) ? 2 : 1;
                er = is_legal(op[win]) ? alu_fn(op[win], a[win], b[win]) : '0;
                ee = !is_legal(op[win]);
            end
        end
        cyc();
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_add();
        test_round_robin();
        test_illegal();
        test_stall();
        test_reset_exec();
        test_wrong_owner();
        test_random(600);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
